mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master round-robin arbiter for the native valid/ready memory bus. It sits between the
//  CPU (m0) plus a DMA/coprocessor master (m1) and the single bus_interface slave port.
//  One transaction is outstanding at a time. A watchdog terminates stalled slave accesses
//  with an error response, so a master never hangs.
// PARAMETERS
//  TIMEOUT_CYCLES  64            max cycles in a grant state without s_ready before error
//  ERR_RDATA       32'hDEADBEEF  read data returned on a timed-out access
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)  watchdog counter width (derived)
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-low reset
//  m0_valid    in   1   CPU request
//  m0_instr    in   1   CPU instruction fetch flag
//  m0_addr     in   32  CPU address
//  m0_wstrb    in   4   CPU byte write strobes (0 = read)
//  m0_wdata    in   32  CPU write data
//  m0_ready    out  1   CPU completion pulse
//  m0_rdata    out  32  CPU read data, valid only while m0_ready=1
//  m1_valid    in   1   DMA request (always a data access)
//  m1_addr     in   32  DMA address
//  m1_wstrb    in   4   DMA byte write strobes
//  m1_wdata    in   32  DMA write data
//  m1_ready    out  1   DMA completion pulse
//  m1_rdata    out  32  DMA read data, valid only while m1_ready=1
//  s_valid     out  1   request to bus_interface
//  s_instr     out  1   fetch flag to slave (owner m0: m0_instr; owner m1: 0)
//  s_addr      out  32  slave address
//  s_wstrb     out  4   slave write strobes
//  s_wdata     out  32  slave write data
//  s_ready     in   1   slave completion
//  s_rdata     in   32  slave read data
//  grant       out  2   one-hot current owner {m1,m0}; 2'b00 when idle
//  bus_err     out  1   one-cycle pulse on watchdog timeout
//  err_master  out  1   owner of the last timed-out access (0=m0, 1=m1); sticky until reset
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, counter 0, last_grant=1 (m0 wins first tie).
//    All outputs 0 next cycle; any in-flight access is abandoned with no ready pulse.
//  - States: IDLE, GNT0, GNT1, all registered.
//  - IDLE: if only one valid is high, go to that master's GNT state. If both are high, go to
//    the master that is not last_grant. If neither, stay.
//  - Arbitration latency: one cycle (valid seen in IDLE; s_valid high from the next cycle).
//  - GNTx: s_valid=1; s_instr/s_addr/s_wstrb/s_wdata mux from owner combinationally.
//    mx_ready=s_ready and mx_rdata=s_rdata in the same cycle.
//  - When s_ready=1 in GNTx: complete, last_grant<=x, counter<=0, next state IDLE.
//    Back-to-back requests from the same master are therefore >=2 cycles apart.
//  - Outside GNTx: s_valid=0, s_addr/s_wstrb/s_wdata=0, mx_ready=0.
//    s_ready is ignored in IDLE; the slave's registered ready may echo one cycle late.
//  - Non-owner master sees ready=0 and must hold its request stable until granted.
//  - Watchdog: counter increments each GNTx cycle with s_ready=0.
//    At counter==TIMEOUT_CYCLES-1 with s_ready=0: owner ready=1 with rdata=ERR_RDATA,
//    bus_err=1, err_master<=x, last_grant<=x, next state IDLE.
//  - s_ready and timeout in the same cycle: normal completion, no bus_err.
//  - A master dropping valid mid-grant is a protocol violation. The grant is held until
//    ready or timeout regardless.
//  - Non-owner rdata outputs are 0.
// TESTING
//  1) Single CPU read addr 0x0020_0010, slave ready 1 cycle after s_valid, rdata 0x1234_5678
//     -> m0_ready pulse with 0x1234_5678; grant 01 for 2 cycles; s_addr=0x0020_0010.
//  2) m0,m1 both valid from reset -> m0 served first, then m1; repeated simultaneous requests
//     alternate m0,m1,m0,m1.
//  3) Slave never ready, TIMEOUT_CYCLES=64 -> owner ready + bus_err exactly 64 cycles after
//     s_valid rises; rdata=0xDEADBEEF; err_master correct; the other master then granted.
//  4) s_ready asserted on cycle 64 (same cycle as timeout) -> normal completion with slave data;
//     bus_err stays 0.
//  5) reset=0 asserted in GNT1 mid-access -> next cycle s_valid=0, grant=00, no m1_ready;
//     first tie after reset goes to m0.
//  6) Slave echoes s_ready one extra cycle after completion -> no extra mx_ready;
//     a pending request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus.
// m0 is the CPU, m1 a DMA/coprocessor master, and the single slave port
// leads to bus_interface. Only one transaction is in flight at a time.
// A watchdog ends stalled slave accesses with an error response, so a
// master is never left waiting forever.
//
// Handshake: a master raises valid with stable instr/addr/wstrb/wdata and
// holds them until it sees its ready pulse. A transfer completes in the
// single cycle where the owner's ready is high. The arbiter raises s_valid
// only while it owns a grant, and treats s_ready as a completion only in
// that state. s_ready seen while idle (a late registered echo from the
// slave) is ignored.
module mem_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF,
    parameter int          CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        bus_err,
    output logic        err_master
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;   // 0 = m0 was served last, 1 = m1
    logic             err_master_q;

    logic own0;
    logic own1;
    logic granted;
    logic timeout;

    assign own0    = (state_q == GNT0);
    assign own1    = (state_q == GNT1);
    assign granted = own0 | own1;

    // A slave answer in the last allowed cycle wins over the watchdog.
    assign timeout = granted && !s_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign s_valid    = granted;
    assign s_instr    = own0 & m0_instr;
    assign grant      = {own1, own0};
    assign bus_err    = timeout;
    assign err_master = err_master_q;

    assign m0_ready = own0 & (s_ready | timeout);
    assign m1_ready = own1 & (s_ready | timeout);
    assign m0_rdata = own0 ? (timeout ? ERR_RDATA : s_rdata) : 32'h0;
    assign m1_rdata = own1 ? (timeout ? ERR_RDATA : s_rdata) : 32'h0;

    // Route the owner's request fields to the slave; drive zeros when idle.
    always_comb begin
        s_addr  = 32'h0;
        s_wstrb = 4'h0;
        s_wdata = 32'h0;
        if (own0) begin
            s_addr  = m0_addr;
            s_wstrb = m0_wstrb;
            s_wdata = m0_wdata;
        end else if (own1) begin
            s_addr  = m1_addr;
            s_wstrb = m1_wstrb;
            s_wdata = m1_wdata;
        end
    end

    // Arbitration FSM with watchdog counter, round-robin pointer and error owner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            err_master_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (m0_valid && m1_valid) begin
                        state_q <= last_grant_q ? GNT0 : GNT1;
                    end else if (m0_valid) begin
                        state_q <= GNT0;
                    end else if (m1_valid) begin
                        state_q <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (s_ready || timeout) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        last_grant_q <= own1;
                        if (timeout) begin
                            err_master_q <= own1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
